// File: rtl/mixcolumns_iter.sv
// Column-serial AES MixColumns: one 32-bit column per cycle, valid/ready on both sides.
// Optional macro MIXCOLUMNS_ITER_INV_EN adds an `inv` port selecting InvMixColumns.
module mixcolumns_iter (
    input  logic         clk,
    input  logic         rst_n,
`ifdef MIXCOLUMNS_ITER_INV_EN
    input  logic         inv,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] mc_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] mc_out,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state;
    logic [127:0] work;
    logic [1:0]   cnt;
    logic         in_rdy_q;
    logic [31:0]  col_cur;
    logic [31:0]  col_new;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_fwd(input logic [31:0] c);
        logic [7:0] s0, s1, s2, s3;
        {s0, s1, s2, s3} = c;
        return {xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3,
                s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3,
                s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3,
                xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3)};
    endfunction

`ifdef MIXCOLUMNS_ITER_INV_EN
    logic inv_q;

    // Row r of the inverse circulant: e, b, d, 9 rotated right by r.
    function automatic logic [7:0] inv_row(input logic [7:0] a, b, c, d);
        logic [7:0] a2, a4, a8, b2, b4, b8, c2, c4, c8, d2, d4, d8;
        a2 = xtime(a); a4 = xtime(a2); a8 = xtime(a4);
        b2 = xtime(b); b4 = xtime(b2); b8 = xtime(b4);
        c2 = xtime(c); c4 = xtime(c2); c8 = xtime(c4);
        d2 = xtime(d); d4 = xtime(d2); d8 = xtime(d4);
        return (a8 ^ a4 ^ a2) ^ (b8 ^ b2 ^ b) ^ (c8 ^ c4 ^ c) ^ (d8 ^ d);
    endfunction

    function automatic logic [31:0] mix_inv(input logic [31:0] c);
        logic [7:0] s0, s1, s2, s3;
        {s0, s1, s2, s3} = c;
        return {inv_row(s0, s1, s2, s3), inv_row(s1, s2, s3, s0),
                inv_row(s2, s3, s0, s1), inv_row(s3, s0, s1, s2)};
    endfunction
`endif

    always_comb begin
        col_cur = work[127:96];
        case (cnt)
            2'd0: col_cur = work[127:96];
            2'd1: col_cur = work[95:64];
            2'd2: col_cur = work[63:32];
            2'd3: col_cur = work[31:0];
            default: col_cur = work[127:96];
        endcase
    end

    always_comb begin
        col_new = mix_fwd(col_cur);
`ifdef MIXCOLUMNS_ITER_INV_EN
        if (inv_q)
            col_new = mix_inv(col_cur);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= '0;
            cnt       <= '0;
            in_rdy_q  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid && in_ready) begin
                    state    <= RUN;
                    work     <= mc_in;
                    cnt      <= '0;
                    in_rdy_q <= 1'b0;
                    busy     <= 1'b1;
                end
                RUN: begin
                    case (cnt)
                        2'd0: work[127:96] <= col_new;
                        2'd1: work[95:64]  <= col_new;
                        2'd2: work[63:32]  <= col_new;
                        2'd3: work[31:0]   <= col_new;
                        default: ;
                    endcase
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_rdy_q  <= 1'b1;
                    busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MIXCOLUMNS_ITER_INV_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            inv_q <= 1'b0;
        else if (state == IDLE && in_valid && in_ready)
            inv_q <= inv;
    end
`endif

    // in_ready must read 0 during reset yet be 1 immediately after release.
    assign in_ready = in_rdy_q & rst_n;
    assign mc_out   = work;

endmodule

// File: tb/tb_mixcolumns_iter.sv
// Directed bench for mixcolumns_iter: FIPS-197 vectors, backpressure, throughput, mid-run reset.
module tb_mixcolumns_iter;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] mc_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] mc_out;
    logic         busy;
`ifdef MIXCOLUMNS_ITER_INV_EN
    logic         inv = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] COL_IN   = 128'hdb135345f20a225c01010101c6c6c6c6;
    localparam logic [127:0] COL_OUT  = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;

    mixcolumns_iter dut (
        .clk(clk), .rst_n(rst_n),
`ifdef MIXCOLUMNS_ITER_INV_EN
        .inv(inv),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .mc_in(mc_in),
        .out_valid(out_valid), .out_ready(out_ready), .mc_out(mc_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Generic shift-and-add GF(2^8) multiply used as the reference model.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input bit inverse);
        logic [7:0] k [4];
        logic [7:0] b [4];
        logic [127:0] r = '0;
        if (inverse) begin k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09; end
        else         begin k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01; end
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) b[i] = s[127 - 32*c - 8*i -: 8];
            for (int row = 0; row < 4; row++) begin
                logic [7:0] acc = 8'h00;
                for (int i = 0; i < 4; i++) acc ^= gmul(b[i], k[(i - row + 4) % 4]);
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    // One transaction; checks 4-edge latency and the result, optionally drains the output.
    task automatic xact(input string tag, input logic [127:0] d, input logic [127:0] exp,
                        input bit drain);
        @(negedge clk);
        chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
        in_valid = 1'b1;
        mc_in    = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_busy"}, 128'(busy), 128'(1));
        for (int k = 1; k < 4; k++) begin
            @(posedge clk); #1;
            chk({tag, "_early_valid"}, 128'(out_valid), 128'(0));
        end
        @(posedge clk); #1;
        chk({tag, "_valid"}, 128'(out_valid), 128'(1));
        chk({tag, "_data"}, mc_out, exp);
        if (drain) begin
            @(negedge clk); out_ready = 1'b1;
            @(posedge clk); #1;
            chk({tag, "_idle"}, 128'(in_ready), 128'(1));
            chk({tag, "_valid_drop"}, 128'(out_valid), 128'(0));
            @(negedge clk); out_ready = 1'b0;
        end
    endtask

    initial begin
        logic [127:0] held;
        logic [127:0] rnd;
        int cyc;
        int acc_cnt;
        int acc_cyc [2];
        bit seen;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_mc_out", mc_out, 128'h0);
        @(negedge clk); rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 128'(in_ready), 128'(1));
        chk("rel_out_valid", 128'(out_valid), 128'(0));
        chk("rel_busy", 128'(busy), 128'(0));

        xact("fips", FIPS_IN, FIPS_OUT, 1'b1);
        xact("cols", COL_IN, COL_OUT, 1'b1);
        rnd = {$urandom, $urandom, $urandom, $urandom};
        xact("rand", rnd, model(rnd, 1'b0), 1'b1);

        // Backpressure: output must hold while in_valid pulses are ignored.
        xact("bp", FIPS_IN, FIPS_OUT, 1'b0);
        held = mc_out;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = k[0];
            mc_in    = COL_IN;
            @(posedge clk); #1;
            chk("bp_hold", mc_out, held);
            chk("bp_valid", 128'(out_valid), 128'(1));
            chk("bp_no_ready", 128'(in_ready), 128'(0));
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", 128'(in_ready), 128'(1));

        // Back-to-back: in_valid and out_ready held high, acceptances 6 cycles apart.
        @(negedge clk);
        in_valid = 1'b1;
        mc_in    = FIPS_IN;
        cyc = 0;
        acc_cnt = 0;
        acc_cyc[0] = 0;
        acc_cyc[1] = 0;
        for (int k = 0; k < 20; k++) begin
            if (in_ready && in_valid && acc_cnt < 2) begin
                acc_cyc[acc_cnt] = cyc;
                acc_cnt++;
            end
            if (out_valid) chk("b2b_data", mc_out, FIPS_OUT);
            if (in_ready && out_valid) chk("b2b_exclusive", 128'(1), 128'(0));
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk("b2b_accepts", 128'(acc_cnt), 128'(2));
        chk("b2b_period", 128'(acc_cyc[1] - acc_cyc[0]), 128'(6));
        repeat (8) @(negedge clk);
        out_ready = 1'b0;

        // Reset two cycles after acceptance discards the in-flight state.
        @(negedge clk);
        in_valid = 1'b1;
        mc_in    = FIPS_IN;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_mc_out", mc_out, 128'h0);
        chk("mid_rst_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_in_ready", 128'(in_ready), 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        out_ready = 1'b0;
        chk("mid_rst_no_output", 128'(seen), 128'(0));
        chk("mid_rst_out_zero", mc_out, 128'h0);
        xact("post_rst", FIPS_IN, FIPS_OUT, 1'b1);

`ifdef MIXCOLUMNS_ITER_INV_EN
        inv = 1'b1;
        xact("inv", FIPS_OUT, FIPS_IN, 1'b1);
        inv = 1'b0;
        xact("inv_fwd", FIPS_OUT, model(FIPS_OUT, 1'b0), 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mixcolumns_iter.md
# mixcolumns_iter

Iterative, column-serial AES MixColumns engine for the encryption datapath. It processes one 32-bit column per clock, so a full 128-bit state takes four cycles with a single shared column multiplier. It is the forward-direction counterpart of the combinational `invmixcolumns` used by the decryption core. Upstream and downstream logic connect through valid/ready handshakes on both sides.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `mc_in` holds a state to transform.
- `in_ready`  out  1  the block accepts a state this cycle.
- `mc_in`  in  128  input AES state. Column 0 is `[127:96]`; within a column, byte 0 is the MSB byte.
- `out_valid`  out  1  `mc_out` holds a completed result.
- `out_ready`  in  1  the consumer accepts the result.
- `mc_out`  out  128  transformed state, same byte layout as `mc_in`.
- `busy`  out  1  high in RUN or DONE.

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - RUN: transforms one column per cycle.
  - DONE: `out_valid`=1.
- IDLE→RUN on `in_valid && in_ready`. At that edge, `mc_in` is captured into a 128-bit working register and the 2-bit column counter is cleared to 0.
- RUN, each cycle:
  - The counter selects column c. Column 0 is `[127:96]` and column 3 is `[31:0]`.
  - Column c of the working register is replaced by its MixColumns result. The other columns are untouched.
  - The counter increments. When the counter is 3, the next state is DONE.
- Forward MixColumns on bytes s0..s3:
  - r0 = 2·s0 ^ 3·s1 ^ s2 ^ s3
  - r1 = s0 ^ 2·s1 ^ 3·s2 ^ s3
  - r2 = s0 ^ s1 ^ 2·s2 ^ 3·s3
  - r3 = 3·s0 ^ s1 ^ s2 ^ 2·s3
- GF(2^8) arithmetic:
  - xtime(b) = {b[6:0],0} ^ (b[7] ? 8'h1b : 0).
  - 3·b = xtime(b) ^ b.
  - All arithmetic is 8-bit; no carries leave a byte.
- DONE: `mc_out` presents the working register.
  - While `out_valid`=1 and `out_ready`=0, the output must hold stable.
  - On `out_valid && out_ready`, go to IDLE.
- `in_valid` is ignored outside IDLE; no input is queued.
- `out_ready` is ignored outside DONE.
- `mc_out` is driven from the working register at all times. It is only meaningful while `out_valid`=1.

## Timing
- Reset values: `in_ready`=0 while `rst_n`=0, then 1 (IDLE). `out_valid`=0, `busy`=0, `mc_out`=128'h0, counter 0.
- Latency: input accepted at edge N; `out_valid` rises after edge N+4.
- With `out_ready` held high, the output handshake completes at edge N+5 and `in_ready` returns after N+5. Best-case throughput is one state per 6 cycles.
- `in_ready` and `out_valid` are registered and never high in the same cycle.
- Reset asserted mid-RUN or mid-DONE:
  - Immediately forces IDLE, clears `out_valid`, `mc_out` and the counter.
  - The in-flight state is discarded and no output is produced.
- Reset deasserted: the first acceptance is possible at the first rising edge after release.

## Configuration
- Macro: `MIXCOLUMNS_ITER_INV_EN`.
- Defined:
  - Adds input port `inv` (1 bit), sampled together with `mc_in` at acceptance and held for the transaction.
  - `inv`=1 applies InvMixColumns coefficients (0e,0b,0d,09 circulant, derived from xtime chains) instead of the forward coefficients.
  - Latency and handshake are identical in both modes.
- Undefined: no `inv` port; forward MixColumns only. Synthesized logic contains no inverse multipliers.

## Test plan
- Reset check: with `rst_n` low, every output is at its reset value. After release, `in_ready`=1, `out_valid`=0, `busy`=0.
- FIPS-197 round 1: `mc_in`=128'hd4bf5d30e0b452aeb84111f11e2798e5 → `mc_out`=128'h046681e5e0cb199a48f8d37a2806264c. `out_valid` rises exactly 4 edges after acceptance.
- Per-column vectors: `mc_in`=128'hdb135345f20a225c01010101c6c6c6c6 → 128'h8e4da1bc9fdc589d01010101c6c6c6c6.
- Backpressure:
  - Hold `out_ready`=0 for 10 cycles after `out_valid`; `mc_out` stays stable and `in_valid` pulses are ignored.
  - Raise `out_ready`; IDLE follows one edge later.
  - Then back-to-back transactions are accepted every 6 cycles.
- Reset mid-operation: assert `rst_n`=0 two cycles after acceptance. `out_valid` never rises and `mc_out`=0. The next transaction after reset completes correctly.
- With `MIXCOLUMNS_ITER_INV_EN` defined: `inv`=1 and `mc_in`=128'h046681e5e0cb199a48f8d37a2806264c → 128'hd4bf5d30e0b452aeb84111f11e2798e5. Then `inv`=0 on the same input → the FIPS-197 forward MixColumns of 128'h046681e5e0cb199a48f8d37a2806264c. The bench computes that expected value with a reference model.
